// File: rtl/xoodyak_cmd_loader_if.sv
// rtl/xoodyak_cmd_loader_if.sv - host command/word handshake and core-facing bus of the loader
interface xoodyak_cmd_loader_if #(
    parameter int CNT_W = 16
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_cont;
    logic             word_valid;
    logic [31:0]      word_data;
    logic             word_ready;
    logic             core_start;
    logic [5:0]       core_opmode;
    logic [351:0]     core_input_data;
    logic             core_finished;
    logic             busy;
    logic [CNT_W-1:0] blocks_done;
    logic             err_illegal;
    logic             err_timeout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_cont, word_valid, word_data, core_finished,
        output cmd_ready, word_ready, core_start, core_opmode, core_input_data,
               busy, blocks_done, err_illegal, err_timeout
    );

    modport master (
        output cmd_valid, cmd_op, cmd_cont, word_valid, word_data, core_finished,
        input  cmd_ready, word_ready, core_start, core_opmode, core_input_data,
               busy, blocks_done, err_illegal, err_timeout
    );
endinterface

// File: rtl/xoodyak_cmd_loader.sv
// rtl/xoodyak_cmd_loader.sv - packs host words into a 352-bit block and sequences start/finish with xoodyak_build
module xoodyak_cmd_loader #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic                 eph1,
    input  logic                 reset,
    xoodyak_cmd_loader_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [5:0]       opmode_q, opmode_d;
    logic [351:0]     data_q, data_d;
    logic [3:0]       widx_q, widx_d;
    logic [3:0]       nwords_q, nwords_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] blocks_q, blocks_d;
    logic             err_ill_q, err_ill_d;
    logic             err_tmo_q, err_tmo_d;
    logic             cmd_ready, word_ready, core_start;
    logic [8:0]       wslot;

    function automatic logic [3:0] words_for(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: words_for = 4'd4;
            3'd3:       words_for = 4'd11;
            3'd4, 3'd5: words_for = 4'd6;
            default:    words_for = 4'd0;
        endcase
    endfunction

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            opmode_q  <= '0;
            data_q    <= '0;
            widx_q    <= '0;
            nwords_q  <= '0;
            tmo_q     <= '0;
            blocks_q  <= '0;
            err_ill_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opmode_q  <= opmode_d;
            data_q    <= data_d;
            widx_q    <= widx_d;
            nwords_q  <= nwords_d;
            tmo_q     <= tmo_d;
            blocks_q  <= blocks_d;
            err_ill_q <= err_ill_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        opmode_d   = opmode_q;
        data_d     = data_q;
        widx_d     = widx_q;
        nwords_d   = nwords_q;
        tmo_d      = tmo_q;
        blocks_d   = blocks_q;
        err_ill_d  = err_ill_q;
        err_tmo_d  = err_tmo_q;
        cmd_ready  = 1'b0;
        word_ready = 1'b0;
        core_start = 1'b0;
        // Word k lands MSB-first: top bit of slot k is 351 - 32k.
        wslot      = 9'd351 - {widx_q, 5'd0};
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (bus.cmd_op == 3'd0) begin
                        err_ill_d = 1'b1;
                    end else begin
                        opmode_d = {bus.cmd_cont, 2'b00, bus.cmd_op};
                        data_d   = '0;
                        widx_d   = '0;
                        nwords_d = words_for(bus.cmd_op);
                        state_d  = (words_for(bus.cmd_op) == 4'd0) ? S_ISSUE : S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                // One settle cycle after the last word keeps start at words+2 cycles.
                if (widx_q == nwords_q) begin
                    state_d = S_ISSUE;
                end else begin
                    word_ready = 1'b1;
                    if (bus.word_valid) begin
                        data_d[wslot -: 32] = bus.word_data;
                        widx_d              = widx_q + 4'd1;
                    end
                end
            end
            S_ISSUE: begin
                core_start = 1'b1;
                tmo_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_finished) begin
                    blocks_d = blocks_q + 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_tmo_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready       = cmd_ready;
    assign bus.word_ready      = word_ready;
    assign bus.core_start      = core_start;
    assign bus.core_opmode     = opmode_q;
    assign bus.core_input_data = data_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.blocks_done     = blocks_q;
    assign bus.err_illegal     = err_ill_q;
    assign bus.err_timeout     = err_tmo_q;
endmodule

// File: tb/tb_xoodyak_cmd_loader.sv
// tb/tb_xoodyak_cmd_loader.sv - directed vector bench for xoodyak_cmd_loader
module tb_xoodyak_cmd_loader;
    logic eph1;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   exp_blocks;

    xoodyak_cmd_loader_if #(.CNT_W(16)) bus ();

    xoodyak_cmd_loader #(.TIMEOUT(1023), .CNT_W(16)) dut (
        .eph1  (eph1),
        .reset (reset),
        .bus   (bus)
    );

    initial eph1 = 1'b0;
    always #5 eph1 = ~eph1;

    typedef struct {
        logic [2:0]        op;
        logic              cont;
        int                nw;
        logic [0:10][31:0] w;
        logic [5:0]        exp_op;
        logic [351:0]      exp_data;
        int                exp_lat;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [351:0] act, input logic [351:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with the loader idle; fin_delay < 0 leaves it waiting in WAIT.
    task automatic run_vec(input int i, input int fin_delay);
        int edges;
        int k;
        int lat;
        int nstart;
        bit seen;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = vecs[i].op;
        bus.cmd_cont  = vecs[i].cont;
        @(posedge eph1); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_cont  = 1'b0;
        edges = 1; k = 0; lat = -1; nstart = 0; seen = 1'b0;
        for (int g = 0; g < 40 && !seen; g++) begin
            bus.word_valid = (k < vecs[i].nw);
            bus.word_data  = (k < vecs[i].nw) ? vecs[i].w[k] : 32'h0;
            @(negedge eph1);
            if (bus.core_start) begin
                seen = 1'b1;
                lat  = edges;
            end else begin
                if (bus.word_ready && bus.word_valid) k++;
                @(posedge eph1); #1;
                edges++;
            end
        end
        bus.word_valid = 1'b0;
        bus.word_data  = 32'h0;
        chk($sformatf("v%0d latency", i), 352'(lat), 352'(vecs[i].exp_lat));
        chk($sformatf("v%0d words", i), 352'(k), 352'(vecs[i].nw));
        chk($sformatf("v%0d opmode", i), 352'(bus.core_opmode), 352'(vecs[i].exp_op));
        chk($sformatf("v%0d data", i), bus.core_input_data, vecs[i].exp_data);
        @(posedge eph1); #1;
        if (fin_delay >= 0) begin
            for (int d = 0; d < fin_delay; d++) begin
                @(negedge eph1);
                if (bus.core_start) nstart++;
                @(posedge eph1); #1;
            end
            bus.core_finished = 1'b1;
            @(negedge eph1);
            if (bus.core_start) nstart++;
            @(posedge eph1); #1;
            bus.core_finished = 1'b0;
            exp_blocks++;
            @(negedge eph1);
            chk($sformatf("v%0d extra starts", i), 352'(nstart), 352'(0));
            chk($sformatf("v%0d busy after finish", i), 352'(bus.busy), 352'(0));
            chk($sformatf("v%0d cmd_ready after finish", i), 352'(bus.cmd_ready), 352'(1));
            chk($sformatf("v%0d blocks_done", i), 352'(bus.blocks_done), 352'(exp_blocks));
            chk($sformatf("v%0d opmode held", i), 352'(bus.core_opmode), 352'(vecs[i].exp_op));
            chk($sformatf("v%0d data held", i), bus.core_input_data, vecs[i].exp_data);
            @(posedge eph1); #1;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " cmd_ready"}, 352'(bus.cmd_ready), 352'(1));
        chk({tag, " word_ready"}, 352'(bus.word_ready), 352'(0));
        chk({tag, " core_start"}, 352'(bus.core_start), 352'(0));
        chk({tag, " busy"}, 352'(bus.busy), 352'(0));
        chk({tag, " opmode"}, 352'(bus.core_opmode), 352'(0));
        chk({tag, " data"}, bus.core_input_data, 352'(0));
        chk({tag, " blocks_done"}, 352'(bus.blocks_done), 352'(0));
        chk({tag, " err_illegal"}, 352'(bus.err_illegal), 352'(0));
        chk({tag, " err_timeout"}, 352'(bus.err_timeout), 352'(0));
    endtask

    initial begin
        int waitcnt;
        n_checks = 0; n_fail = 0; exp_blocks = 0;

        vecs[0] = '{op: 3'd1, cont: 1'b0, nw: 4,
                    w: {32'h38393a3b, 32'h3c3d3e3f, 32'h30313233, 32'h34353637, 224'h0},
                    exp_op: 6'h01, exp_data: {128'h38393a3b3c3d3e3f3031323334353637, 224'h0}, exp_lat: 6};
        vecs[1] = '{op: 3'd3, cont: 1'b1, nw: 11,
                    w: {32'h61626364, 32'h65666768, 32'h696a6b6c, 32'h6d6e6f70, 32'h71727374, 32'h75767778,
                        32'h797a7b7c, 32'h7d7e7f80, 32'h81828384, 32'h85868788, 32'h898a8b8c},
                    exp_op: 6'h23,
                    exp_data: 352'h6162636465666768696a6b6c6d6e6f707172737475767778797a7b7c7d7e7f80818283848586878889_8a8b8c,
                    exp_lat: 13};
        vecs[2] = '{op: 3'd2, cont: 1'b0, nw: 4,
                    w: {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 224'h0},
                    exp_op: 6'h02, exp_data: {128'h11111111222222223333333344444444, 224'h0}, exp_lat: 6};
        vecs[3] = '{op: 3'd4, cont: 1'b1, nw: 6,
                    w: {32'ha0a1a2a3, 32'ha4a5a6a7, 32'ha8a9aaab, 32'hacadaeaf, 32'hb0b1b2b3, 32'hb4b5b6b7, 160'h0},
                    exp_op: 6'h24, exp_data: {192'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7, 160'h0}, exp_lat: 8};
        vecs[4] = '{op: 3'd7, cont: 1'b0, nw: 0, w: 352'h0,
                    exp_op: 6'h07, exp_data: 352'h0, exp_lat: 1};
        vecs[5] = '{op: 3'd5, cont: 1'b0, nw: 6,
                    w: {32'h4d4e4f50, 32'h51525354, 32'h55565758, 32'h595a5b5c, 32'h5d5e5f60, 32'h61626364, 160'h0},
                    exp_op: 6'h05, exp_data: {192'h4d4e4f505152535455565758595a5b5c5d5e5f6061626364, 160'h0}, exp_lat: 8};
        vecs[6] = '{op: 3'd4, cont: 1'b0, nw: 6,
                    w: {32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10, 32'h11121314, 32'h15161718, 160'h0},
                    exp_op: 6'h04, exp_data: {192'h0102030405060708090a0b0c0d0e0f101112131415161718, 160'h0}, exp_lat: 8};

        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_cont = 1'b0;
        bus.word_valid = 1'b0; bus.word_data = 32'h0; bus.core_finished = 1'b0;
        #1;
        chk_reset_state("reset");
        repeat (2) @(posedge eph1);
        #1 reset = 1'b0;

        run_vec(0, 3);
        run_vec(1, 0);

        // Squeeze: finish pulse during ISSUE must be ignored.
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd6; bus.cmd_cont = 1'b0;
        @(posedge eph1); #1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0;
        bus.core_finished = 1'b1;
        @(negedge eph1);
        chk("squeeze start", 352'(bus.core_start), 352'(1));
        chk("squeeze word_ready", 352'(bus.word_ready), 352'(0));
        chk("squeeze opmode", 352'(bus.core_opmode), 352'(6'h06));
        chk("squeeze data", bus.core_input_data, 352'(0));
        @(posedge eph1); #1;
        bus.core_finished = 1'b0;
        @(negedge eph1);
        chk("squeeze issue finish ignored busy", 352'(bus.busy), 352'(1));
        chk("squeeze issue finish ignored blocks", 352'(bus.blocks_done), 352'(exp_blocks));
        chk("squeeze wait word_ready", 352'(bus.word_ready), 352'(0));
        @(posedge eph1); #1;
        bus.core_finished = 1'b1;
        @(posedge eph1); #1;
        bus.core_finished = 1'b0;
        exp_blocks++;
        @(negedge eph1);
        chk("squeeze done busy", 352'(bus.busy), 352'(0));
        chk("squeeze done blocks", 352'(bus.blocks_done), 352'(exp_blocks));
        @(posedge eph1); #1;

        // Illegal op 0: flag only, no capture.
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_cont = 1'b1;
        @(posedge eph1); #1;
        bus.cmd_valid = 1'b0; bus.cmd_cont = 1'b0;
        @(negedge eph1);
        chk("illegal err", 352'(bus.err_illegal), 352'(1));
        chk("illegal busy", 352'(bus.busy), 352'(0));
        chk("illegal cmd_ready", 352'(bus.cmd_ready), 352'(1));
        chk("illegal start", 352'(bus.core_start), 352'(0));
        chk("illegal opmode held", 352'(bus.core_opmode), 352'(6'h06));
        @(posedge eph1); #1;
        run_vec(2, 1);
        chk("illegal sticky", 352'(bus.err_illegal), 352'(1));

        run_vec(3, 2);
        run_vec(4, 1);

        // Timeout: no finish, expect exactly 1023 WAIT cycles.
        run_vec(6, -1);
        @(negedge eph1);
        chk("timeout err before", 352'(bus.err_timeout), 352'(0));
        waitcnt = 0;
        for (int g = 0; g < 1100; g++) begin
            if (g > 0) @(negedge eph1);
            if (!bus.busy) break;
            waitcnt++;
            @(posedge eph1); #1;
        end
        chk("timeout wait cycles", 352'(waitcnt), 352'(1023));
        chk("timeout err", 352'(bus.err_timeout), 352'(1));
        chk("timeout cmd_ready", 352'(bus.cmd_ready), 352'(1));
        chk("timeout blocks unchanged", 352'(bus.blocks_done), 352'(exp_blocks));
        @(posedge eph1); #1;

        // Reset after 3 of 6 crypt words.
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd4; bus.cmd_cont = 1'b0;
        @(posedge eph1); #1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0;
        for (int k = 0; k < 3; k++) begin
            bus.word_valid = 1'b1;
            bus.word_data  = 32'hf0f0f0f0 ^ 32'(k);
            @(posedge eph1); #1;
        end
        @(negedge eph1);
        chk("midload busy", 352'(bus.busy), 352'(1));
        chk("midload word_ready", 352'(bus.word_ready), 352'(1));
        #2 reset = 1'b1;
        #1;
        bus.word_valid = 1'b0;
        chk_reset_state("midload reset");
        @(posedge eph1); #1;
        reset = 1'b0;
        exp_blocks = 0;
        run_vec(5, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
